// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the RV32 pipeline hazard/sequencing controller.
// State encoding, register-file address width and the hard-wired zero register index.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } ctrl_state_e;

  localparam int REG_AW_DEF = 5;
  localparam logic [REG_AW_DEF-1:0] X0_IDX = '0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-control outputs exchanged between the controller and the datapath.
// master is the controller side; slave is the pipeline stages it steers.
interface pipeline_ctrl_if #(
  parameter int REG_AW = cpu_ctrl_pkg::REG_AW_DEF,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rs1_if_id;
  logic [REG_AW-1:0] rs2_if_id;
  logic              use_rs1_if_id;
  logic              use_rs2_if_id;
  logic [REG_AW-1:0] write_reg_id_exe;
  logic              ctrl_mem_read_id_exe;
  logic              branch_taken_mem;
  logic              mem_req_exe_mem;
  logic              mem_ready;

  logic              pc_en;
  logic              if_id_en;
  logic              id_exe_en;
  logic              exe_mem_en;
  logic              mem_wb_en;
  logic              if_id_flush;
  logic              id_exe_flush;
  logic              exe_mem_flush;
  logic              mem_timeout_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    input  rs1_if_id, rs2_if_id, use_rs1_if_id, use_rs2_if_id,
           write_reg_id_exe, ctrl_mem_read_id_exe, branch_taken_mem,
           mem_req_exe_mem, mem_ready,
    output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
           if_id_flush, id_exe_flush, exe_mem_flush,
           mem_timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    output rs1_if_id, rs2_if_id, use_rs1_if_id, use_rs2_if_id,
           write_reg_id_exe, ctrl_mem_read_id_exe, branch_taken_mem,
           mem_req_exe_mem, mem_ready,
    input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
           if_id_flush, id_exe_flush, exe_mem_flush,
           mem_timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an IF/ID instruction that reads the destination of a load in ID/EX.
// Writes to x0 never create a dependency.
module hazard_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic [REG_AW-1:0] write_reg_i,
  input  logic              mem_read_i,
  output logic              load_use_o
);

  assign load_use_o = mem_read_i
                    & (write_reg_i != REG_AW'(X0_IDX))
                    & ((use_rs1_i & (rs1_i == write_reg_i))
                     | (use_rs2_i & (rs2_i == write_reg_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage enable/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-resolved
// branch flushes, data-memory wait with watchdog, and saturating stall/flush counters.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.master bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              err_q, err_d;

  logic load_use, mem_miss;
  logic hold, flush_br, bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .rs1_i       (bus.rs1_if_id),
    .rs2_i       (bus.rs2_if_id),
    .use_rs1_i   (bus.use_rs1_if_id),
    .use_rs2_i   (bus.use_rs2_if_id),
    .write_reg_i (bus.write_reg_id_exe),
    .mem_read_i  (bus.ctrl_mem_read_id_exe),
    .load_use_o  (load_use)
  );

  assign mem_miss = bus.mem_req_exe_mem & ~bus.mem_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    wait_d   = wait_q;
    hold     = 1'b0;
    flush_br = 1'b0;
    bubble   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_miss) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_ready) begin
          hold   = 1'b1;
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d >= WAIT_W'(MEM_TIMEOUT)) state_d = TIMEOUT;
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      TIMEOUT: hold = 1'b1;
      default: begin
        hold    = 1'b1;
        state_d = RUN;
      end
    endcase
    // A branch seen while frozen is acted on only once the pipeline advances.
    if (!hold) begin
      if (bus.branch_taken_mem) flush_br = 1'b1;
      else if (load_use)        bubble   = 1'b1;
    end
  end

  assign bus.pc_en         = ~hold & ~bubble;
  assign bus.if_id_en      = ~hold & ~bubble;
  assign bus.id_exe_en     = ~hold;
  assign bus.exe_mem_en    = ~hold;
  assign bus.mem_wb_en     = ~hold;
  assign bus.if_id_flush   = flush_br;
  assign bus.id_exe_flush  = flush_br | bubble;
  assign bus.exe_mem_flush = flush_br;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!bus.pc_en && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    if (flush_br   && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
    err_d = err_q | (state_d == TIMEOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so all state registers update together from pre-edge values.
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall_cnt       = stall_q;
  assign bus.flush_cnt       = flush_q;
  assign bus.mem_timeout_err = err_q;

  illegal_branch_with_mem_a : assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_req_exe_mem && bus.branch_taken_mem));

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32 pipeline (IF, ID, EXE, MEM, WB).
- Drives per-stage register enables and flushes. Covers three cases:
  - load-use stall;
  - taken-branch flush, with the branch resolved in MEM;
  - multi-cycle data-memory wait, with a timeout watchdog.
- Sits beside the stage modules and also keeps saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register address width
CNT_W, 32, width of performance counters
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rs1_if_id  in  REG_AW  rs1 field of instruction in IF/ID
rs2_if_id  in  REG_AW  rs2 field of instruction in IF/ID
use_rs1_if_id  in  1  instruction in IF/ID reads rs1
use_rs2_if_id  in  1  instruction in IF/ID reads rs2
write_reg_id_exe  in  REG_AW  destination register in ID/EX
ctrl_mem_read_id_exe  in  1  ID/EX holds a load
branch_taken_mem  in  1  branch in MEM resolved taken (ctrl_branch & zero)
mem_req_exe_mem  in  1  EX/MEM instruction reads or writes data memory
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
id_exe_en  out  1  ID/EX register enable
exe_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
if_id_flush  out  1  zero IF/ID on next edge
id_exe_flush  out  1  zero ID/EX (insert bubble) on next edge
exe_mem_flush  out  1  zero EX/MEM on next edge
mem_timeout_err  out  1  sticky watchdog error
stall_cnt  out  CNT_W  cycles lost to stalls
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- FSM states: RUN, MEM_WAIT, TIMEOUT.
- Reset (async, any time, including mid-wait):
  - state is RUN; wait counter, stall_cnt, flush_cnt and mem_timeout_err are 0.
  - All enables read 1 and all flushes read 0 (the RUN/no-hazard values).
- Enables and flushes are Mealy outputs (combinational from state plus inputs). Counters and error are registered.
- mem_miss = mem_req_exe_mem & ~mem_ready.
- load_use = ctrl_mem_read_id_exe & (write_reg_id_exe != 0) & ((use_rs1_if_id & rs1_if_id == write_reg_id_exe) | (use_rs2_if_id & rs2_if_id == write_reg_id_exe)).
- RUN, priority order (highest first):
  1. mem_miss:
     - all five enables = 0, no flush;
     - next state MEM_WAIT, wait counter = 1.
  2. branch_taken_mem:
     - all enables = 1;
     - if_id_flush = id_exe_flush = exe_mem_flush = 1;
     - load_use is ignored;
     - flush_cnt += 1.
  3. load_use:
     - pc_en = if_id_en = 0; id_exe_en = 1, id_exe_flush = 1 (bubble);
     - exe_mem_en = mem_wb_en = 1;
     - exactly one stall cycle: the bubble clears ctrl_mem_read_id_exe.
  4. Otherwise: all enables 1, flushes 0.
- MEM_WAIT:
  - mem_ready = 1: all enables 1, next state RUN, wait counter cleared. The same-cycle branch/load_use rules of RUN apply.
  - mem_ready = 0:
    - all enables 0; wait counter += 1;
    - if wait counter == MEM_TIMEOUT, next state TIMEOUT.
  - A branch_taken_mem asserted while in MEM_WAIT is held, not acted on; it is acted on in the cycle the pipeline advances.
- TIMEOUT: all enables 0, no flushes, mem_timeout_err = 1. Left only by reset.
- stall_cnt += 1 on every cycle in which pc_en = 0. This covers load_use, mem_miss, MEM_WAIT and TIMEOUT.
- Both counters saturate at all-ones; they do not wrap.
- mem_req_exe_mem and branch_taken_mem both high is illegal (a branch makes no memory access). Simulation assertion; RTL gives mem_miss priority.
- Latency: zero cycles from hazard inputs to enable/flush outputs. Counters update at the next edge.

Decomposition:
- Shared package cpu_ctrl_pkg, holding:
  - state encoding localparams: RUN = 2'd0, MEM_WAIT = 2'd1, TIMEOUT = 2'd2;
  - register address width 5;
  - x0 index constant.
- One sub-module: hazard_detect, a purely combinational load_use comparator that takes the six ID-side inputs. All sequential logic stays in pipeline_ctrl.

Test Plan:
- Load-use:
  - Stimulus: ID/EX lw x5 (mem_read = 1, write_reg = 5); IF/ID add x6,x5,x1 (rs1 = 5, use_rs1 = 1).
  - Response: one cycle pc_en = 0, if_id_en = 0, id_exe_flush = 1, stall_cnt 0->1; next cycle all enables 1.
- Load to x0:
  - Stimulus: write_reg_id_exe = 0, rs1_if_id = 0, use_rs1 = 1, mem_read = 1.
  - Response: no stall, stall_cnt stays 0.
- Taken branch coinciding with load-use:
  - Stimulus: branch_taken_mem = 1 with a load-use pattern present.
  - Response: all three flushes 1, pc_en = 1, flush_cnt = 1, stall_cnt unchanged.
- Memory wait:
  - Stimulus: mem_req = 1, mem_ready low for 3 cycles then high.
  - Response: enables 0 for 3 cycles, 1 on the ready cycle, state back to RUN, stall_cnt = 3.
- Timeout:
  - Stimulus: MEM_TIMEOUT = 4, mem_req = 1, mem_ready held 0.
  - Response: mem_timeout_err = 1 after 4 wait cycles and stays set; rst pulse mid-TIMEOUT clears it asynchronously, enables return to 1.
- Counter saturation:
  - Stimulus: CNT_W = 3, 10 consecutive branch flushes.
  - Response: flush_cnt holds at 7.
